// File: rtl/counter_seq_pkg.sv
// Shared encodings for the counter sequencer: FSM states, sequence modes,
// the latched configuration record and the 8-bit step helper.
package counter_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_RELOAD   = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [1:0] MODE_RSVD     = 2'd3;

  // Configuration captured when a sequence is launched.
  typedef struct packed {
    logic [7:0] start_v;
    logic [7:0] end_v;
    logic       dir;
    logic [1:0] mode;
  } seq_cfg_t;

  // One counter step, wrapping modulo 256 in either direction.
  function automatic logic [7:0] step8(input logic [7:0] q, input logic up);
    return up ? (q + 8'd1) : (q - 8'd1);
  endfunction

endpackage

// File: rtl/counter_seq_ctrl_presc.sv
// Tick prescaler: down-counter that fires when it reaches zero and then
// reloads. Also exposes whether the *next* cycle will tick so the parent
// can register its counter-enable one cycle ahead.
module seq_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_reload,
  input  logic               i_run,
  input  logic [PRESC_W-1:0] i_val,
  output logic               o_tick,
  output logic               o_tick_nx
);

  logic [PRESC_W-1:0] r_cnt;
  logic [PRESC_W-1:0] w_cnt_nx;

  // Next count: explicit reload, or count down and wrap to the reload value.
  always_comb begin
    w_cnt_nx = r_cnt;
    if (i_reload)           w_cnt_nx = i_val;
    else if (i_run) begin
      if (r_cnt == '0)      w_cnt_nx = i_val;
      else                  w_cnt_nx = r_cnt - PRESC_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= w_cnt_nx;
  end

  assign o_tick    = (r_cnt == '0);
  assign o_tick_nx = (w_cnt_nx == '0);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for the 8-bit loadable up/down counter: one-shot, auto-reload
// or ping-pong runs between a start and an end value at a prescaled rate.
// Every output is a flop; the counter enable is decided one cycle early
// from the predicted counter value so a step lands on the tick cycle.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int PRESC_W = 8,
  parameter int WRAP_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [7:0]         i_cfg_start,
  input  logic [7:0]         i_cfg_end,
  input  logic               i_cfg_dir,
  input  logic [1:0]         i_cfg_mode,
  input  logic [PRESC_W-1:0] i_cfg_presc,
  input  logic [7:0]         i_cnt_q,
  output logic               o_cnt_en,
  output logic               o_cnt_load,
  output logic               o_cnt_up,
  output logic               o_cnt_oe,
  output logic [7:0]         o_cnt_d,
  output logic               o_busy,
  output logic               o_done,
  output logic [WRAP_W-1:0]  o_passes
);

  logic [1:0]         r_state;
  seq_cfg_t           r_cfg;
  logic [PRESC_W-1:0] r_presc;
  logic [7:0]         r_endc;
  logic               r_dir;
  logic [WRAP_W-1:0]  r_passes;
  logic               r_en, r_load, r_oe, r_busy, r_done;

  logic               w_ptick, w_ptick_nx, w_tick, w_term;
  logic [1:0]         w_state_nx;
  logic               w_dir_nx, w_latch, w_pass_inc;
  logic [7:0]         w_endc_nx, w_q_nx;

  seq_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_reload  (r_state == ST_LOAD),
    .i_run     (r_state == ST_RUN),
    .i_val     (r_presc),
    .o_tick    (w_ptick),
    .o_tick_nx (w_ptick_nx)
  );

  assign w_tick = (r_state == ST_RUN) & w_ptick;
  assign w_term = w_tick & (i_cnt_q == r_endc);

  // Counter value after this edge, assuming it obeys what we drive now.
  assign w_q_nx = r_load ? r_cfg.start_v :
                  r_en   ? step8(i_cnt_q, r_dir) : i_cnt_q;

  // FSM next state plus direction / terminal-value bookkeeping.
  always_comb begin
    w_state_nx = r_state;
    w_dir_nx   = r_dir;
    w_endc_nx  = r_endc;
    w_latch    = 1'b0;
    w_pass_inc = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start && !i_stop) begin
        w_state_nx = ST_LOAD;
        w_latch    = 1'b1;
        w_dir_nx   = i_cfg_dir;
        w_endc_nx  = i_cfg_end;
      end
      ST_LOAD: w_state_nx = i_stop ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (i_stop) w_state_nx = ST_IDLE;
        else if (w_term) begin
          case (r_cfg.mode)
            MODE_RELOAD: begin
              w_state_nx = ST_LOAD;
              w_pass_inc = 1'b1;
            end
            MODE_PINGPONG: begin
              w_dir_nx   = ~r_dir;
              w_endc_nx  = (r_endc == r_cfg.end_v) ? r_cfg.start_v : r_cfg.end_v;
              w_pass_inc = 1'b1;
            end
            MODE_ONESHOT, MODE_RSVD: w_state_nx = ST_DONE;
            default:                 w_state_nx = ST_DONE;
          endcase
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // State, shadow config and saturating pass counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cfg    <= '0;
      r_presc  <= '0;
      r_endc   <= '0;
      r_dir    <= 1'b1;
      r_passes <= '0;
    end else begin
      r_state <= w_state_nx;
      r_dir   <= w_dir_nx;
      r_endc  <= w_endc_nx;
      if (w_latch) begin
        r_cfg    <= '{start_v: i_cfg_start, end_v: i_cfg_end,
                      dir: i_cfg_dir, mode: i_cfg_mode};
        r_presc  <= i_cfg_presc;
        r_passes <= '0;
      end else if (w_pass_inc && !(&r_passes)) begin
        r_passes <= r_passes + WRAP_W'(1);
      end
    end
  end

  // Registered counter controls and status, computed for the coming cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en   <= 1'b0;
      r_load <= 1'b0;
      r_oe   <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_load <= (w_state_nx == ST_LOAD);
      r_en   <= (w_state_nx == ST_LOAD) |
                ((w_state_nx == ST_RUN) & w_ptick_nx & (w_q_nx != w_endc_nx));
      r_oe   <= 1'b1;
      r_busy <= (w_state_nx == ST_LOAD) | (w_state_nx == ST_RUN);
      r_done <= (w_state_nx == ST_DONE);
    end
  end

  assign o_cnt_en   = r_en;
  assign o_cnt_load = r_load;
  assign o_cnt_up   = r_dir;
  assign o_cnt_oe   = r_oe;
  assign o_cnt_d    = r_cfg.start_v;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_passes   = r_passes;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: a behavioural 8-bit counter closes the loop,
// a cycle model of the sequencing rules checks every cycle, directed
// vectors pin down exact count traces, and random traffic runs at the end.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, cfg_dir;
  logic [7:0] cfg_start, cfg_end, cfg_presc, cnt_q, cnt_d, passes;
  logic [1:0] cfg_mode;
  logic       cnt_en, cnt_load, cnt_up, cnt_oe, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.PRESC_W(8), .WRAP_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .i_cfg_start(cfg_start), .i_cfg_end(cfg_end), .i_cfg_dir(cfg_dir),
    .i_cfg_mode(cfg_mode), .i_cfg_presc(cfg_presc), .i_cnt_q(cnt_q),
    .o_cnt_en(cnt_en), .o_cnt_load(cnt_load), .o_cnt_up(cnt_up),
    .o_cnt_oe(cnt_oe), .o_cnt_d(cnt_d), .o_busy(busy), .o_done(done),
    .o_passes(passes)
  );

  // Stand-in for the loadable up/down counter the sequencer drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_q <= 8'd0;
    else if (cnt_load) cnt_q <= cnt_d;
    else if (cnt_en)   cnt_q <= cnt_up ? cnt_q + 8'd1 : cnt_q - 8'd1;
  end

  // ---------------- reference model (phase: 0 idle, 1 load, 2 run, 3 done)
  int m_ph, m_pc, m_q, m_dir, m_leg, m_start, m_end, m_mode, m_presc, m_passes;

  task automatic model_reset();
    m_ph = 0; m_pc = 0; m_q = 0; m_dir = 1; m_leg = 0;
    m_start = 0; m_end = 0; m_mode = 0; m_presc = 0; m_passes = 0;
  endtask

  function automatic int target();
    return m_leg ? m_start : m_end;
  endfunction

  function automatic int e_load();
    return (m_ph == 1) ? 1 : 0;
  endfunction

  function automatic int e_en();
    return (m_ph == 1 || (m_ph == 2 && m_pc == 0 && m_q != target())) ? 1 : 0;
  endfunction

  task automatic model_step();
    int nq;
    if (!rst_n) begin model_reset(); return; end
    nq = m_q;
    if (e_load() == 1)    nq = m_start;
    else if (e_en() == 1) nq = m_dir ? (m_q + 1) % 256 : (m_q + 255) % 256;
    case (m_ph)
      0: if (start && !stop) begin
        m_ph = 1; m_passes = 0; m_leg = 0;
        m_start = cfg_start; m_end = cfg_end; m_dir = cfg_dir;
        m_mode = cfg_mode; m_presc = cfg_presc;
      end
      1: if (stop) m_ph = 0; else begin m_ph = 2; m_pc = m_presc; end
      2: if (stop) m_ph = 0;
         else begin
           bit tk;
           tk = (m_pc == 0);
           m_pc = tk ? m_presc : m_pc - 1;
           if (tk && m_q == target()) begin
             if (m_mode == 1) begin
               m_ph = 1; m_passes = (m_passes < 255) ? m_passes + 1 : 255;
             end else if (m_mode == 2) begin
               m_dir = 1 - m_dir; m_leg = 1 - m_leg;
               m_passes = (m_passes < 255) ? m_passes + 1 : 255;
             end else m_ph = 3;
           end
         end
      default: m_ph = 0;
    endcase
    m_q = nq;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("cnt_en",   int'(cnt_en),   e_en());
    chk("cnt_load", int'(cnt_load), e_load());
    chk("cnt_up",   int'(cnt_up),   m_dir);
    chk("cnt_oe",   int'(cnt_oe),   1);
    chk("cnt_d",    int'(cnt_d),    m_start);
    chk("busy",     int'(busy),     (m_ph == 1 || m_ph == 2) ? 1 : 0);
    chk("done",     int'(done),     (m_ph == 3) ? 1 : 0);
    chk("passes",   int'(passes),   m_passes);
    chk("cnt_q",    int'(cnt_q),    m_q);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic scramble_cfg();
    cfg_start = 8'($urandom); cfg_end = 8'($urandom);
    cfg_dir = 1'($urandom); cfg_mode = 2'($urandom); cfg_presc = 8'($urandom);
  endtask

  // ---------------- directed vectors: q/done traced from the first RUN cycle
  typedef struct {
    logic [7:0]      s, e;
    logic            dir;
    logic [1:0]      mode;
    logic [7:0]      presc;
    logic [0:7][7:0] q;
    logic [0:7]      dm;
    int              np;
  } vec_t;

  vec_t vt [7];

  initial begin
    int k;
    vt[0] = '{8'd5,   8'd9,   1'b1, 2'd0, 8'd0, {8'd5,8'd6,8'd7,8'd8,8'd9,8'd9,8'd9,8'd9}, 8'b0000_0100, 0};
    vt[1] = '{8'd3,   8'd1,   1'b0, 2'd1, 8'd1, {8'd3,8'd3,8'd2,8'd2,8'd1,8'd1,8'd1,8'd3}, 8'b0000_0000, 1};
    vt[2] = '{8'd10,  8'd12,  1'b1, 2'd2, 8'd0, {8'd10,8'd11,8'd12,8'd12,8'd11,8'd10,8'd10,8'd11}, 8'b0000_0000, 2};
    vt[3] = '{8'd254, 8'd1,   1'b1, 2'd0, 8'd0, {8'd254,8'd255,8'd0,8'd1,8'd1,8'd1,8'd1,8'd1}, 8'b0000_1000, 0};
    vt[4] = '{8'd1,   8'd254, 1'b0, 2'd3, 8'd0, {8'd1,8'd0,8'd255,8'd254,8'd254,8'd254,8'd254,8'd254}, 8'b0000_1000, 0};
    vt[5] = '{8'd42,  8'd42,  1'b1, 2'd0, 8'd0, {8'd42,8'd42,8'd42,8'd42,8'd42,8'd42,8'd42,8'd42}, 8'b0100_0000, 0};
    vt[6] = '{8'd7,   8'd8,   1'b1, 2'd0, 8'd2, {8'd7,8'd7,8'd7,8'd8,8'd8,8'd8,8'd8,8'd8}, 8'b0000_0010, 0};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_start = 8'd0; cfg_end = 8'd0; cfg_dir = 1'b0; cfg_mode = 2'd0; cfg_presc = 8'd0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cyc();

    // Table-driven traces; cfg is scrambled after launch to prove it was latched.
    foreach (vt[v]) begin
      cfg_start = vt[v].s; cfg_end = vt[v].e; cfg_dir = vt[v].dir;
      cfg_mode = vt[v].mode; cfg_presc = vt[v].presc; start = 1'b1;
      cyc();
      start = 1'b0; scramble_cfg();
      cyc();
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("v%0d_q%0d", v, i), int'(cnt_q), int'(vt[v].q[i]));
        chk($sformatf("v%0d_done%0d", v, i), int'(done), int'(vt[v].dm[i]));
        if (i == 7) chk($sformatf("v%0d_passes", v), int'(passes), vt[v].np);
        else cyc();
      end
      stop = 1'b1; cyc(); stop = 1'b0; cyc();
    end

    // Stop mid-run while the counter shows 7: goes idle, value frozen, no done.
    cfg_start = 8'd5; cfg_end = 8'd20; cfg_dir = 1'b1; cfg_mode = 2'd0; cfg_presc = 8'd3;
    start = 1'b1; cyc(); start = 1'b0;
    k = 0;
    while (cnt_q != 8'd7 && k < 100) begin cyc(); k++; end
    chk("stop_wait_q7", (k < 100) ? 1 : 0, 1);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_q", int'(cnt_q), 7);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stop_hold_q", int'(cnt_q), 7);
      chk("stop_no_done", int'(done), 0);
    end
    start = 1'b1; stop = 1'b1; cyc(); cyc();
    chk("startstop_idle", int'(busy), 0);
    start = 1'b0; stop = 1'b0; cyc();

    // Ping-pong on a single value turns every cycle: passes must saturate.
    cfg_start = 8'd9; cfg_end = 8'd9; cfg_dir = 1'b1; cfg_mode = 2'd2; cfg_presc = 8'd0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 300; i++) cyc();
    chk("passes_sat", int'(passes), 255);
    chk("passes_sat_q", int'(cnt_q), 9);
    stop = 1'b1; cyc(); stop = 1'b0; cyc();

    // Asynchronous reset in the middle of a run.
    cfg_start = 8'd0; cfg_end = 8'd200; cfg_dir = 1'b1; cfg_mode = 2'd0; cfg_presc = 8'd0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      start = ($urandom_range(3) == 0);
      stop  = ($urandom_range(49) == 0);
      cfg_start = 8'($urandom);
      cfg_end   = ($urandom_range(7) == 0) ? 8'($urandom)
                                           : 8'(cfg_start + 8'($urandom_range(12)) - 8'd6);
      cfg_dir   = 1'($urandom);
      cfg_mode  = 2'($urandom);
      cfg_presc = 8'($urandom_range(3));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
